demux_1x2_32bit_buf: RTL and testbench

Buffered 1-to-2 demultiplexer for 32-bit datapath words: one valid/ready input stream is steered by a per-word select bit into one of two valid/ready output streams. Each branch has a 2-entry FIFO, so a stalled consumer on one branch does not block words bound for the other. It sits on the datapath wherever a single producer feeds two independent consumers, such as splitting a result bus between the write-back path and a store path.

---
 rtl/demux_1x2_32bit_buf.sv | 71 +++++++
 tb/tb_demux_1x2_32bit_buf.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x2_32bit_buf.sv
// Buffered 1-to-2 demultiplexer: one valid/ready input stream is steered by in_sel
// into one of two valid/ready output streams, each behind its own 2-entry FIFO.
module demux_1x2_32bit_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready
);

    // Index 0 is branch 1 (in_sel = 0), index 1 is branch 2 (in_sel = 1).
    logic [WIDTH-1:0] mem [2][2];
    logic [1:0]       count [2];
    logic [1:0]       rd_ptr;
    logic [1:0]       wr_ptr;
    logic [1:0]       push;
    logic [1:0]       pop;

    // in_ready looks only at registered counts, never at the consumers' ready.
    assign in_ready = in_sel ? (count[1] != 2'd2) : (count[0] != 2'd2);

    assign push[0] = in_valid & in_ready & ~in_sel;
    assign push[1] = in_valid & in_ready &  in_sel;
    assign pop[0]  = (count[0] != 2'd0) & out1_ready;
    assign pop[1]  = (count[1] != 2'd0) & out2_ready;

    assign out1_valid = (count[0] != 2'd0);
    assign out2_valid = (count[1] != 2'd0);
    assign out1_data  = mem[0][rd_ptr[0]];
    assign out2_data  = mem[1][rd_ptr[1]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the entries are reset too, so idle out*_data reads as 0 after reset.
            for (int b = 0; b < 2; b++) begin
                mem[b][0] <= '0;
                mem[b][1] <= '0;
                count[b]  <= 2'd0;
            end
            rd_ptr <= 2'b00;
            wr_ptr <= 2'b00;
        end else begin
            // NOTE: non-blocking updates keep every branch reading pre-edge state.
            for (int b = 0; b < 2; b++) begin
                if (push[b]) begin
                    mem[b][wr_ptr[b]] <= in_data;
                    wr_ptr[b]         <= ~wr_ptr[b];
                end
                if (pop[b]) begin
                    rd_ptr[b] <= ~rd_ptr[b];
                end
                // Simultaneous push and pop leaves the occupancy unchanged.
                unique case ({push[b], pop[b]})
                    2'b10:   count[b] <= count[b] + 2'd1;
                    2'b01:   count[b] <= count[b] - 2'd1;
                    default: count[b] <= count[b];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_demux_1x2_32bit_buf.sv
// Self-checking bench for demux_1x2_32bit_buf: directed scenarios plus random traffic,
// checked by a monitor against per-branch word queues.
module tb_demux_1x2_32bit_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out1_data;
    logic        out1_valid;
    logic        out1_ready = 1'b0;
    logic [31:0] out2_data;
    logic        out2_valid;
    logic        out2_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: words accepted but not yet consumed, per branch, in order.
    logic [31:0] q1[$];
    logic [31:0] q2[$];

    bit random_done = 1'b0;

    demux_1x2_32bit_buf #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: on every falling edge compare DUT outputs with the queues, then
    // apply the handshakes that the next rising edge will perform.
    logic prev_hold = 1'b0;
    logic prev_sel  = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_ready;
            logic pop1, pop2;
            exp_ready = in_sel ? (q2.size() < 2) : (q1.size() < 2);
            check("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
            check("out2_valid", {31'd0, out2_valid}, {31'd0, q2.size() != 0});
            check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            if (prev_hold && in_valid)
                check("sel_stable", {31'd0, in_sel}, {31'd0, prev_sel});
            pop1 = (q1.size() != 0) && out1_ready;
            pop2 = (q2.size() != 0) && out2_ready;
            if (q1.size() != 0) check("out1_data", out1_data, q1[0]);
            if (q2.size() != 0) check("out2_data", out2_data, q2[0]);
            if (pop1) void'(q1.pop_front());
            if (pop2) void'(q2.pop_front());
            if (in_valid && exp_ready) begin
                if (in_sel) q2.push_back(in_data);
                else        q1.push_back(in_data);
            end
            prev_hold = in_valid && !in_ready;
            prev_sel  = in_sel;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // All driver activity happens 1 time unit after a rising edge.
    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic s);
        int waited;
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        waited   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                check("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        // Reset state, then idle for three cycles.
        #12 rst_n = 1'b1;
        idle(3);
        check("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        check("rst_out2_valid", {31'd0, out2_valid}, 32'd0);
        check("rst_out1_data", out1_data, 32'd0);
        check("rst_out2_data", out2_data, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic steering with both consumers ready.
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        send(32'h1111_1111, 1'b0);
        send(32'h2222_2222, 1'b1);
        send(32'h3333_3333, 1'b0);
        idle(3);
        check("basic_drain1", q1.size(), 32'd0);
        check("basic_drain2", q2.size(), 32'd0);

        // Branch 1 stalled: third word must wait for the consumer.
        out1_ready = 1'b0;
        send(32'hA000_0001, 1'b0);
        send(32'hA000_0002, 1'b0);
        in_data  = 32'hA000_0003;
        in_sel   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        out1_ready = 1'b1;
        send(32'hA000_0003, 1'b0);
        idle(4);
        check("stall_drain1", q1.size(), 32'd0);

        // Full branch 1 does not throttle words for branch 2.
        out1_ready = 1'b0;
        send(32'hE000_0001, 1'b0);
        send(32'hE000_0002, 1'b0);
        in_data  = 32'hB000_0001;
        in_sel   = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("other_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("other_out2_valid", {31'd0, out2_valid}, 32'd1);
        check("other_out2_data", out2_data, 32'hB000_0001);
        out1_ready = 1'b1;
        idle(4);
        check("other_drain1", q1.size(), 32'd0);
        check("other_drain2", q2.size(), 32'd0);

        // Push and pop together at count 1, across several pointer wraps.
        out1_ready = 1'b0;
        send(32'hC000_0001, 1'b0);
        for (int i = 0; i < 10; i++) begin
            logic [31:0] w;
            w = 32'hC000_0002 + 32'(i);
            out1_ready = 1'b1;
            send(w, 1'b0);
            out1_ready = 1'b0;
            check("pp_out1_valid", {31'd0, out1_valid}, 32'd1);
            check("pp_out1_data", out1_data, w);
        end
        out1_ready = 1'b1;
        idle(3);
        check("pp_drain1", q1.size(), 32'd0);

        // Asynchronous reset between clock edges with both branches full.
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        send(32'hF000_0001, 1'b0);
        send(32'hF000_0002, 1'b1);
        send(32'hF000_0003, 1'b0);
        send(32'hF000_0004, 1'b1);
        #1 rst_n = 1'b0;
        q1.delete();
        q2.delete();
        #1;
        check("arst_out1_valid", {31'd0, out1_valid}, 32'd0);
        check("arst_out2_valid", {31'd0, out2_valid}, 32'd0);
        check("arst_out1_data", out1_data, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out2_ready = 1'b1;
        send(32'hD000_0001, 1'b1);
        check("post_rst_out2_data", out2_data, 32'hD000_0001);
        check("post_rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        idle(3);

        // Random traffic with randomly stalling consumers.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send($urandom, 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                random_done = 1'b1;
            end
            begin
                while (!random_done) begin
                    @(posedge clk);
                    #1;
                    out1_ready = ($urandom_range(0, 2) != 0);
                    out2_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        idle(5);
        check("rand_drain1", q1.size(), 32'd0);
        check("rand_drain2", q2.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
